// File: rtl/elevator_call_scheduler_if.sv
// ----------------------------------------------------------------------------
// elevator_call_scheduler_if
// Bundles the call-panel and car-datapath signals of the elevator call
// scheduler so they can be passed as one port.
//
// Handshake between scheduler and car (the only handshake on this bus):
//   move_up / move_down is a level request. It is raised by the scheduler and
//   held, unchanged, every cycle until the car returns a one-cycle step_done
//   pulse. step_done completes exactly one one-floor step, and cur_floor
//   must be valid in that same cycle. A step_done with no request
//   outstanding is ignored.
//
// Signals (direction seen from the scheduler, i.e. the slave modport):
//   call_btn   in   N_FLOORS  call buttons, one bit per floor, any pulse width
//   cur_floor  in   FLOOR_W   car position from the datapath
//   step_done  in   1         one-floor step complete (1-cycle pulse)
//   door_hold  in   1         door obstruction / hold
//   move_up    out  1         step the car up one floor
//   move_down  out  1         step the car down one floor
//   door_open  out  1         door open at cur_floor
//   dir_up     out  1         current scan direction (1 = up)
//   pending    out  N_FLOORS  latched, unserved calls
//   busy       out  1         scheduler not idle or calls pending
//   dbg_state  out  2         FSM state, for observation only
// ----------------------------------------------------------------------------
interface elevator_call_scheduler_if #(
    parameter int N_FLOORS = 4,
    parameter int FLOOR_W  = 2
);
    logic [N_FLOORS-1:0] call_btn;
    logic [FLOOR_W-1:0]  cur_floor;
    logic                step_done;
    logic                door_hold;
    logic                move_up;
    logic                move_down;
    logic                door_open;
    logic                dir_up;
    logic [N_FLOORS-1:0] pending;
    logic                busy;
    logic [1:0]          dbg_state;

    // Panel / car side.
    modport master (
        output call_btn, cur_floor, step_done, door_hold,
        input  move_up, move_down, door_open, dir_up, pending, busy, dbg_state
    );

    // Scheduler side.
    modport slave (
        input  call_btn, cur_floor, step_done, door_hold,
        output move_up, move_down, door_open, dir_up, pending, busy, dbg_state
    );
endinterface

// File: rtl/elevator_call_scheduler.sv
// ----------------------------------------------------------------------------
// elevator_call_scheduler
// Latches floor calls and sequences the car with collective (SCAN)
// scheduling: keep stepping in the current direction while calls lie ahead,
// reverse when only calls behind remain. Issues one-floor step commands and
// times the door at each served floor.
//
// Ports:
//   clk      in  1   rising-edge clock
//   reset_n  in  1   asynchronous active-low reset
//   bus      slave modport of elevator_call_scheduler_if (calls, car
//                    handshake, door, status and debug state)
//
// All outputs are registers or decodes of registered state only.
// ----------------------------------------------------------------------------
module elevator_call_scheduler #(
    parameter int N_FLOORS    = 4,
    parameter int FLOOR_W     = 2,
    parameter int DOOR_CYCLES = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    elevator_call_scheduler_if.slave   bus
);
    localparam int CNT_W = $clog2(DOOR_CYCLES + 1);
    localparam logic [CNT_W-1:0] DOOR_LOAD = CNT_W'(DOOR_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MOVE = 2'd1,
        S_DOOR = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic                dir_up_q, dir_up_d;
    logic [N_FLOORS-1:0] pending_q, pending_d;
    logic [CNT_W-1:0]    door_cnt_q, door_cnt_d;

    logic [N_FLOORS-1:0] floor_onehot;
    logic [N_FLOORS-1:0] calls_above;
    logic [N_FLOORS-1:0] calls_below;
    logic [N_FLOORS-1:0] clear_mask;
    logic [N_FLOORS-1:0] call_mask;
    logic                here_call;
    logic                any_above;
    logic                any_below;
    logic                door_reload;

    // Position decode. A cur_floor outside 0..N_FLOORS-1 matches no bit of
    // floor_onehot, so it never selects a pending call to serve.
    always_comb begin
        floor_onehot = '0;
        calls_above  = '0;
        calls_below  = '0;
        for (int i = 0; i < N_FLOORS; i++) begin
            floor_onehot[i] = (bus.cur_floor == FLOOR_W'(i));
            calls_above[i]  = pending_q[i] && (i > int'(bus.cur_floor));
            calls_below[i]  = pending_q[i] && (i < int'(bus.cur_floor));
        end
    end

    assign here_call   = |(pending_q & floor_onehot);
    assign any_above   = |calls_above;
    assign any_below   = |calls_below;
    // A call button at the open floor behaves like a hold: it re-opens the door.
    assign door_reload = bus.door_hold || (|(bus.call_btn & floor_onehot));

    always_comb begin
        state_d    = state_q;
        dir_up_d   = dir_up_q;
        door_cnt_d = door_cnt_q;
        clear_mask = '0;
        call_mask  = bus.call_btn;

        case (state_q)
            S_IDLE: begin
                if (here_call) begin
                    // Clearing on the entry edge also absorbs a same-cycle
                    // press of this floor's button.
                    state_d    = S_DOOR;
                    door_cnt_d = DOOR_LOAD;
                    clear_mask = floor_onehot;
                end else if (dir_up_q ? any_above : any_below) begin
                    state_d = S_MOVE;
                end else if (dir_up_q ? any_below : any_above) begin
                    dir_up_d = ~dir_up_q;
                    state_d  = S_MOVE;
                end
            end
            S_MOVE: begin
                if (bus.step_done) begin
                    state_d = S_IDLE;
                end
            end
            S_DOOR: begin
                // The served floor's button is not latched while the door is open.
                call_mask = bus.call_btn & ~floor_onehot;
                if (door_reload) begin
                    door_cnt_d = DOOR_LOAD;
                end else if (door_cnt_q <= CNT_W'(1)) begin
                    state_d    = S_IDLE;
                    door_cnt_d = '0;
                end else begin
                    door_cnt_d = door_cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        pending_d = (pending_q | call_mask) & ~clear_mask;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            dir_up_q   <= 1'b1;
            pending_q  <= '0;
            door_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            dir_up_q   <= dir_up_d;
            pending_q  <= pending_d;
            door_cnt_q <= door_cnt_d;
        end
    end

    assign bus.move_up   = (state_q == S_MOVE) &&  dir_up_q;
    assign bus.move_down = (state_q == S_MOVE) && !dir_up_q;
    assign bus.door_open = (state_q == S_DOOR);
    assign bus.dir_up    = dir_up_q;
    assign bus.pending   = pending_q;
    assign bus.busy      = (state_q != S_IDLE) || (|pending_q);
    assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_elevator_call_scheduler.sv
// ----------------------------------------------------------------------------
// tb_elevator_call_scheduler
// Directed scenarios followed by random call batches. A car model answers
// each step request after CAR_DELAY cycles. Expected service order comes from
// a floor-level SCAN planner: serve the current floor, sweep onward to every
// call ahead, then reverse for the rest.
// ----------------------------------------------------------------------------
module tb_elevator_call_scheduler;
    localparam int N           = 4;
    localparam int FW          = 2;
    localparam int DOOR_CYCLES = 4;
    localparam int CAR_DELAY   = 3;
    localparam int BUDGET      = 600;

    logic clk;
    logic reset_n;

    elevator_call_scheduler_if #(.N_FLOORS(N), .FLOOR_W(FW)) bus ();

    elevator_call_scheduler #(
        .N_FLOORS(N), .FLOOR_W(FW), .DOOR_CYCLES(DOOR_CYCLES)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- bench state ----------------
    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    int car_floor = 0;
    int door_run  = 0;
    int door_at   = 0;
    int move_run  = 0;
    int first_door_cyc = -1;
    int call_cyc  = 0;

    logic [N-1:0] drv_call       = '0;
    logic         drv_spur       = 1'b0;
    logic [N-1:0] move_call_mask = '0;
    logic [N-1:0] pend_chk       = '0;
    int           hold_left      = 0;
    int           door_call_at   = 0;
    logic [N-1:0] door_call_mask = '0;

    // Observed logs.
    int   door_floor_log[$];
    int   door_len_log[$];
    logic move_log[$];

    // Reference model state and expectations.
    int           model_floor = 0;
    logic         model_dir   = 1'b1;
    logic [FW-1:0] exp_q[$];
    logic         exp_move_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // SCAN planner on whole floors: fills exp_q with the served floors and
    // exp_move_q with one entry per one-floor step (1 = up).
    function automatic void plan(input logic [N-1:0] mask);
        int f = model_floor;
        logic [N-1:0] p = mask;
        logic ahead;
        exp_q.delete();
        exp_move_q.delete();
        if (p[f]) begin
            exp_q.push_back(FW'(f));
            p[f] = 1'b0;
        end
        while (p != '0) begin
            ahead = 1'b0;
            for (int i = 0; i < N; i++)
                if (p[i] && (model_dir ? (i > f) : (i < f))) ahead = 1'b1;
            if (!ahead) model_dir = !model_dir;
            do begin
                f = model_dir ? f + 1 : f - 1;
                exp_move_q.push_back(model_dir);
            end while (!p[f]);
            exp_q.push_back(FW'(f));
            p[f] = 1'b0;
        end
        model_floor = f;
    endfunction

    // One clock: observe at the falling edge, then drive the next inputs.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (pend_chk != '0) begin
            check("move_call_latched", bus.pending & pend_chk, pend_chk);
            pend_chk = '0;
        end
        if (bus.door_open) begin
            if (door_run == 0) begin
                door_at = car_floor;
                if (first_door_cyc < 0) first_door_cyc = cyc;
            end
            door_run++;
        end else if (door_run != 0) begin
            door_floor_log.push_back(door_at);
            door_len_log.push_back(door_run);
            door_run = 0;
        end
        if (bus.move_up || bus.move_down) begin
            if (move_run == 0) begin
                move_log.push_back(bus.move_up);
                check("move_exclusive", (bus.move_up & bus.move_down) | bus.door_open, 0);
                check("move_boundary",
                      (bus.move_up && car_floor == N - 1) || (bus.move_down && car_floor == 0), 0);
            end
            move_run++;
        end else begin
            move_run = 0;
        end

        bus.call_btn  = drv_call;
        drv_call      = '0;
        bus.step_done = drv_spur;
        drv_spur      = 1'b0;
        bus.door_hold = 1'b0;
        if (move_run == CAR_DELAY) begin
            bus.step_done = 1'b1;
            car_floor = bus.move_up ? car_floor + 1 : car_floor - 1;
            if (car_floor < 0) car_floor = 0;
            if (car_floor > N - 1) car_floor = N - 1;
            bus.cur_floor = FW'(car_floor);
        end
        if (move_run == 1 && move_call_mask != '0) begin
            bus.call_btn = bus.call_btn | move_call_mask;
            pend_chk = move_call_mask;
            move_call_mask = '0;
        end
        if (bus.door_open && hold_left > 0) begin
            bus.door_hold = 1'b1;
            hold_left--;
        end
        if (bus.door_open && door_call_at != 0 && door_run == door_call_at) begin
            bus.call_btn = bus.call_btn | door_call_mask;
            door_call_at = 0;
        end
    endtask

    // Press drive_mask once, let the scheduler finish, then compare what
    // happened with the plan for model_mask.
    task automatic serve(input logic [N-1:0] drive_mask, input logic [N-1:0] model_mask,
                         input int first_len, input string tag);
        int n;
        plan(model_mask);
        door_floor_log.delete();
        door_len_log.delete();
        move_log.delete();
        first_door_cyc = -1;
        drv_call = drive_mask;
        tick();
        call_cyc = cyc;
        n = 0;
        do begin
            tick();
            n++;
        end while ((bus.busy || door_run != 0) && n < BUDGET);
        check({tag, "_timeout"}, n < BUDGET, 1);
        check({tag, "_door_count"}, door_floor_log.size(), exp_q.size());
        foreach (exp_q[i]) begin
            if (i < door_floor_log.size()) begin
                check({tag, "_door_floor"}, door_floor_log[i], exp_q[i]);
                check({tag, "_door_len"}, door_len_log[i], (i == 0) ? first_len : DOOR_CYCLES);
            end
        end
        check({tag, "_move_count"}, move_log.size(), exp_move_q.size());
        foreach (exp_move_q[i]) begin
            if (i < move_log.size()) check({tag, "_move_dir"}, move_log[i], exp_move_q[i]);
        end
        check({tag, "_dir_up"}, bus.dir_up, model_dir);
        check({tag, "_pending"}, bus.pending, 0);
        check({tag, "_car_floor"}, car_floor, model_floor);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        logic [N-1:0] m;

        reset_n       = 1'b0;
        bus.call_btn  = '0;
        bus.cur_floor = '0;
        bus.step_done = 1'b0;
        bus.door_hold = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Reset state.
        check("rst_move_up", bus.move_up, 0);
        check("rst_move_down", bus.move_down, 0);
        check("rst_door_open", bus.door_open, 0);
        check("rst_dir_up", bus.dir_up, 1);
        check("rst_pending", bus.pending, 0);
        check("rst_busy", bus.busy, 0);

        // Call at the car's own floor: door opens the edge after the call is latched.
        serve(4'b0001, 4'b0001, DOOR_CYCLES, "t1");
        check("t1_door_latency", first_door_cyc - call_cyc, 2);

        // Stray step_done while idle must not start anything.
        drv_spur = 1'b1;
        tick();
        tick();
        check("spur_step_idle", {bus.move_up, bus.move_down, bus.busy}, 0);

        // Three up steps to the top floor.
        serve(4'b1000, 4'b1000, DOOR_CYCLES, "t2");

        // Reset in the middle of a down move with calls 3 and 1 latched.
        drv_call = 4'b0010;
        move_call_mask = 4'b1000;
        n = 0;
        do begin
            tick();
            n++;
        end while (move_run != 2 && n < 20);
        check("t6_reach_move", n < 20, 1);
        check("t6_pending_before", bus.pending, 4'b1010);
        check("t6_dir_before", bus.dir_up, 0);
        #2 reset_n = 1'b0;
        #1;
        check("t6_async_outputs", {bus.move_up, bus.move_down, bus.door_open}, 0);
        check("t6_async_pending", bus.pending, 0);
        check("t6_async_dir", bus.dir_up, 1);
        @(negedge clk);
        reset_n   = 1'b1;
        move_run  = 0;
        door_run  = 0;
        pend_chk  = '0;
        bus.step_done = 1'b0;
        model_dir = 1'b1;
        model_floor = car_floor;
        repeat (5) tick();
        check("t6_stays_idle", {bus.move_up, bus.move_down, bus.door_open, bus.busy}, 0);

        // Reposition: down to 0, then up to 1 so the scan direction is up.
        serve(4'b0001, 4'b0001, DOOR_CYCLES, "pos0");
        serve(4'b0010, 4'b0010, DOOR_CYCLES, "pos1");

        // From floor 1 going up with calls at 3 and 0.
        serve(4'b1001, 4'b1001, DOOR_CYCLES, "t3");

        // Door hold for 10 cycles at floor 2.
        hold_left = 10;
        serve(4'b0100, 4'b0100, 10 + DOOR_CYCLES, "t4_hold");

        // Own-floor button in the door's 2nd cycle re-opens it; floor 0 call is latched.
        door_call_at = 2;
        door_call_mask = 4'b0101;
        serve(4'b0100, 4'b0101, 2 + DOOR_CYCLES, "t4_call");

        // Call for floor 2 arrives during the first step of an upward sweep to 3.
        move_call_mask = 4'b0100;
        serve(4'b1000, 4'b1100, DOOR_CYCLES, "t5");

        // Random call batches.
        for (int k = 0; k < 20; k++) begin
            m = N'($urandom_range(1, (1 << N) - 1));
            serve(m, m, DOOR_CYCLES, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
